i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_pkg.sv | 8 +
 rtl/i2s_timing.sv | 54 +++++
 rtl/i2s_tx.sv | 129 ++++++++++++
 tb/tb_i2s_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter slice.
package i2s_pkg;

    // MODE parameter values.
    localparam int MODE_I2S = 0;  // lr leads the MSB by one bit-clock
    localparam int MODE_LJ  = 1;  // lr changes together with the MSB

endpackage

// File: rtl/i2s_timing.sv
// Bit-clock generator and frame position counters.
// b/s hold the position that the next fall presents, so that when fall
// is high they name the position being put on the wire at that edge.
module i2s_timing #(
    parameter int DIV = 16,
    parameter int SW  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ck,
    output logic                  fall,
    output logic [$clog2(SW)-1:0] b,
    output logic                  s
);

    localparam int CW = $clog2(DIV);
    localparam int BW = $clog2(SW);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == CW'(DIV - 1));
    // The fall strobe is high on the clock whose edge takes ck from 1 to 0.
    assign fall = tick & ck;

    // Divider: toggle ck every DIV clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            ck  <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            ck  <= ~ck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Position counters: advance b on each fall, flip slot when b wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b <= '0;
            s <= 1'b0;
        end else if (fall) begin
            if (b == BW'(SW - 1)) begin
                b <= '0;
                s <= ~s;
            end else begin
                b <= b + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S / left-justified serial transmitter: sample handshake, holding and
// frame registers, and the MSB-first output shifter.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DW   = 16,
    parameter int SW   = 16,
    parameter int DIV  = 16,
    parameter int MODE = MODE_I2S
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] l,
    input  logic [DW-1:0] r,
    input  logic          valid,
    output logic          ready,
    output logic          ck,
    output logic          lr,
    output logic          d,
    output logic          underrun
);

    localparam int BW = $clog2(SW);

    logic          fall;
    logic          s;
    logic [BW-1:0] b;
    logic          frame_start;
    logic          hs;
    logic          hold_full;
    logic [DW-1:0] hold_l;
    logic [DW-1:0] hold_r;
    logic [DW-1:0] frame_l;
    logic [DW-1:0] frame_r;
    logic [DW-1:0] slot_word;
    logic [SW-1:0] padded;
    logic [SW-1:0] sh;

    i2s_timing #(
        .DIV (DIV),
        .SW  (SW)
    ) u_timing (
        .clock (clock),
        .reset (reset),
        .ck    (ck),
        .fall  (fall),
        .b     (b),
        .s     (s)
    );

    // valid/ready: a pair transfers on every rising edge where valid and
    // ready are both high; l/r are sampled only on that edge, valid may rise
    // independently of ready, and ready means "holding register empty".
    assign ready       = ~hold_full;
    assign hs          = valid & ready;
    assign frame_start = fall & ~s & (b == '0);

    // Select the word that starts a slot; a frame start uses the pair that
    // the frame register is about to take.
    always_comb begin
        slot_word = s ? frame_r : frame_l;
        if (frame_start) begin
            if (hold_full) begin
                slot_word = hold_l;
            end else if (hs) begin
                slot_word = l;
            end else begin
                slot_word = frame_l;
            end
        end
        padded             = '0;
        padded[SW-1 -: DW] = slot_word;
    end

    // Holding and frame registers, plus the underrun pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            frame_l   <= '0;
            frame_r   <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_start) begin
                if (hold_full) begin
                    frame_l   <= hold_l;
                    frame_r   <= hold_r;
                    hold_full <= 1'b0;
                end else if (hs) begin
                    // Pair offered exactly at frame start goes straight out.
                    frame_l <= l;
                    frame_r <= r;
                end else begin
                    // Nothing new: the frame register repeats the last pair.
                    underrun <= 1'b1;
                end
            end else if (hs) begin
                hold_l    <= l;
                hold_r    <= r;
                hold_full <= 1'b1;
            end
        end
    end

    // Output shifter and word select, updated only on falls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh <= '0;
            d  <= 1'b0;
            lr <= (MODE == MODE_I2S);
        end else if (fall) begin
            if (b == '0) begin
                d  <= padded[SW-1];
                sh <= {padded[SW-2:0], 1'b0};
            end else begin
                d  <= sh[SW-1];
                sh <= {sh[SW-2:0], 1'b0};
            end
            if (MODE == MODE_LJ) begin
                lr <= s;
            end else begin
                lr <= (b == BW'(SW - 1)) ? ~s : s;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: three instances (I2S 16/16, left-justified 16/16,
// left-justified 24-in-32 with a fast bit clock) checked every cycle
// against a frame-level model, plus directed literal checks.
module tb_i2s_tx;

    logic        clock;
    logic        rst_n;
    logic [15:0] l_ab;
    logic [15:0] r_ab;
    logic        v_ab;
    logic [23:0] l_c;
    logic [23:0] r_c;
    logic        v_c;

    wire  [2:0]  rdy;
    wire  [2:0]  ck_o;
    wire  [2:0]  lr_o;
    wire  [2:0]  d_o;
    wire  [2:0]  un_o;

    int total;
    int bad;

    i2s_tx #(.DW(16), .SW(16), .DIV(16), .MODE(0)) dut_a (
        .clock (clock), .reset (rst_n), .l (l_ab), .r (r_ab), .valid (v_ab),
        .ready (rdy[0]), .ck (ck_o[0]), .lr (lr_o[0]), .d (d_o[0]), .underrun (un_o[0])
    );

    i2s_tx #(.DW(16), .SW(16), .DIV(16), .MODE(1)) dut_b (
        .clock (clock), .reset (rst_n), .l (l_ab), .r (r_ab), .valid (v_ab),
        .ready (rdy[1]), .ck (ck_o[1]), .lr (lr_o[1]), .d (d_o[1]), .underrun (un_o[1])
    );

    i2s_tx #(.DW(24), .SW(32), .DIV(2), .MODE(1)) dut_c (
        .clock (clock), .reset (rst_n), .l (l_c), .r (r_c), .valid (v_c),
        .ready (rdy[2]), .ck (ck_o[2]), .lr (lr_o[2]), .d (d_o[2]), .underrun (un_o[2])
    );

    // Clock: 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int div_of(int i);
        return (i == 2) ? 2 : 16;
    endfunction

    function automatic int sw_of(int i);
        return (i == 2) ? 32 : 16;
    endfunction

    function automatic int dw_of(int i);
        return (i == 2) ? 24 : 16;
    endfunction

    function automatic int mode_of(int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic logic vin(int i);
        return (i < 2) ? v_ab : v_c;
    endfunction

    function automatic logic [31:0] lin(int i);
        return (i < 2) ? {16'h0, l_ab} : {8'h0, l_c};
    endfunction

    function automatic logic [31:0] rin(int i);
        return (i < 2) ? {16'h0, r_ab} : {8'h0, r_c};
    endfunction

    // A frame starts on the edge that completes the first bit-clock period
    // of every 2*SW-bit frame, counting edges since reset release.
    function automatic logic frame_start_at(int i, int kk);
        int per;
        per = 2 * div_of(i);
        return (kk % per == 0) && (((kk / per) - 1) % (2 * sw_of(i)) == 0);
    endfunction

    // Model state: edges since release, pending pair, current frame pair.
    int          k    [3];
    logic        pend [3];
    logic [31:0] pl   [3];
    logic [31:0] pr   [3];
    logic [31:0] cl   [3];
    logic [31:0] cr   [3];
    logic        eu   [3];

    // Model: sample handshake and frame boundaries in frame/edge terms.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                k[i]    <= 0;
                pend[i] <= 1'b0;
                pl[i]   <= '0;
                pr[i]   <= '0;
                cl[i]   <= '0;
                cr[i]   <= '0;
                eu[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                eu[i] <= 1'b0;
                if (frame_start_at(i, k[i] + 1)) begin
                    if (pend[i]) begin
                        cl[i]   <= pl[i];
                        cr[i]   <= pr[i];
                        pend[i] <= 1'b0;
                    end else if (vin(i)) begin
                        cl[i] <= lin(i);
                        cr[i] <= rin(i);
                    end else begin
                        eu[i] <= 1'b1;
                    end
                end else if (vin(i) && !pend[i]) begin
                    pl[i]   <= lin(i);
                    pr[i]   <= rin(i);
                    pend[i] <= 1'b1;
                end
                k[i] <= k[i] + 1;
            end
        end
    end

    // Observation state gathered at each negedge.
    int          cyc;
    int          un_cnt  [3];
    int          rdy_cnt [3];
    int          d_ones  [3];
    logic [63:0] cap_d   [3];
    logic [63:0] cap_l   [3];
    int          last_ck_rise;
    int          last_lr_rise;
    int          ck_per;
    int          lr_per;
    logic        prev_ck;
    logic        prev_lr;

    task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, int i, logic act, logic exp);
        chk(name, i, 64'(act), 64'(exp));
    endtask

    // One clock: compare every output of every instance against the model,
    // then gather statistics and frame captures.
    task automatic tick();
        int          dv;
        int          sw;
        int          dw;
        int          p;
        int          slot;
        int          bt;
        logic [31:0] w;
        logic        e_ck;
        logic        e_lr;
        logic        e_d;
        @(negedge clock);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            dv   = div_of(i);
            sw   = sw_of(i);
            dw   = dw_of(i);
            p    = (k[i] >= 2 * dv) ? (k[i] / (2 * dv)) - 1 : -1;
            e_ck = ((k[i] / dv) % 2) == 1;
            if (p < 0) begin
                e_d  = 1'b0;
                e_lr = (mode_of(i) == 0);
            end else begin
                slot = (p / sw) % 2;
                bt   = p % sw;
                w    = (slot == 1) ? cr[i] : cl[i];
                e_d  = (bt < dw) ? w[dw - 1 - bt] : 1'b0;
                e_lr = (mode_of(i) == 1) ? (slot == 1) : ((((p + 1) / sw) % 2) == 1);
            end
            chk1("ck", i, ck_o[i], e_ck);
            chk1("lr", i, lr_o[i], e_lr);
            chk1("d", i, d_o[i], e_d);
            chk1("ready", i, rdy[i], !pend[i]);
            chk1("underrun", i, un_o[i], eu[i]);
            if (rst_n) begin
                un_cnt[i]  += int'(un_o[i]);
                rdy_cnt[i] += int'(rdy[i]);
                d_ones[i]  += int'(d_o[i]);
                if (p >= 0 && p < 64) begin
                    cap_d[i][63 - p] = d_o[i];
                    cap_l[i][63 - p] = lr_o[i];
                end
            end
        end
        if (ck_o[0] && !prev_ck) begin
            if (last_ck_rise >= 0) ck_per = cyc - last_ck_rise;
            last_ck_rise = cyc;
        end
        if (lr_o[1] && !prev_lr) begin
            if (last_lr_rise >= 0) lr_per = cyc - last_lr_rise;
            last_lr_rise = cyc;
        end
        prev_ck = ck_o[0];
        prev_lr = lr_o[1];
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (3) tick();
    endtask

    // Release reset at a negedge and clear the observation state.
    task automatic release_rst();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            un_cnt[i]  = 0;
            rdy_cnt[i] = 0;
            d_ones[i]  = 0;
            cap_d[i]   = '0;
            cap_l[i]   = '0;
        end
        last_ck_rise = -1;
        last_lr_rise = -1;
        ck_per       = 0;
        lr_per       = 0;
        prev_ck      = 1'b0;
        prev_lr      = 1'b0;
    endtask

    task automatic set_pair(logic [15:0] la, logic [15:0] ra, logic [23:0] lc, logic [23:0] rc, logic v);
        l_ab = la;
        r_ab = ra;
        l_c  = lc;
        r_c  = rc;
        v_ab = v;
        v_c  = v;
    endtask

    task automatic chk_reset_outputs(string name);
        for (int i = 0; i < 3; i++) begin
            chk1({name, "_ck"}, i, ck_o[i], 1'b0);
            chk1({name, "_d"}, i, d_o[i], 1'b0);
            chk1({name, "_ready"}, i, rdy[i], 1'b1);
            chk1({name, "_underrun"}, i, un_o[i], 1'b0);
        end
        chk1({name, "_lr"}, 0, lr_o[0], 1'b1);
        chk1({name, "_lr"}, 1, lr_o[1], 1'b0);
        chk1({name, "_lr"}, 2, lr_o[2], 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        set_pair(16'h0, 16'h0, 24'h0, 24'h0, 1'b0);
        release_rst();
        rst_n = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk_reset_outputs("reset");

        // Idle: no samples offered, zeros repeated, one underrun per frame.
        release_rst();
        repeat (3100) tick();
        chk("idle_ck_period", 0, 64'(ck_per), 64'd32);
        chk("idle_lr_period", 1, 64'(lr_per), 64'd1024);
        chk("idle_underruns", 0, 64'(un_cnt[0]), 64'd3);
        chk("idle_underruns", 1, 64'(un_cnt[1]), 64'd3);
        chk("idle_underruns", 2, 64'(un_cnt[2]), 64'd13);
        chk("idle_d_ones", 0, 64'(d_ones[0]), 64'd0);
        chk("idle_d_ones", 2, 64'(d_ones[2]), 64'd0);

        // One pair offered before the first frame, then valid low.
        hold_reset();
        set_pair(16'hA5F0, 16'h0F5A, 24'h800001, 24'h123456, 1'b1);
        release_rst();
        tick();
        chk1("hs_ready_drop", 0, rdy[0], 1'b0);
        chk1("hs_ready_drop", 2, rdy[2], 1'b0);
        v_ab = 1'b0;
        v_c  = 1'b0;
        repeat (1099) tick();
        chk("frame_d", 0, 64'(cap_d[0][63:32]), 64'h00000000A5F00F5A);
        chk("frame_d", 1, 64'(cap_d[1][63:32]), 64'h00000000A5F00F5A);
        chk("frame_lr_i2s", 0, 64'(cap_l[0][63:32]), 64'h000000000001FFFE);
        chk("frame_lr_lj", 1, 64'(cap_l[1][63:32]), 64'h000000000000FFFF);
        chk("frame_d_24in32", 2, cap_d[2], 64'h8000010012345600);
        chk("frame_lr_24in32", 2, cap_l[2], 64'h00000000FFFFFFFF);
        chk("first_frame_underruns", 0, 64'(un_cnt[0]), 64'd1);
        chk("first_frame_underruns", 2, 64'(un_cnt[2]), 64'd4);

        // valid held high with fresh data every clock.
        hold_reset();
        set_pair(16'h1234, 16'h5678, 24'h9ABCDE, 24'h0F0F0F, 1'b1);
        release_rst();
        repeat (3000) begin
            tick();
            set_pair(16'($urandom), 16'($urandom), 24'($urandom), 24'($urandom), 1'b1);
        end
        chk("stream_ready_cycles", 0, 64'(rdy_cnt[0]), 64'd3);
        chk("stream_ready_cycles", 1, 64'(rdy_cnt[1]), 64'd3);
        chk("stream_ready_cycles", 2, 64'(rdy_cnt[2]), 64'd12);
        chk("stream_underruns", 0, 64'(un_cnt[0]), 64'd0);
        chk("stream_underruns", 2, 64'(un_cnt[2]), 64'd0);

        // Reset asserted mid-frame at bit 7 of the right slot.
        hold_reset();
        set_pair(16'hA5F0, 16'h0F5A, 24'h800001, 24'h123456, 1'b1);
        release_rst();
        tick();
        v_ab = 1'b0;
        v_c  = 1'b0;
        repeat (789) tick();
        chk1("midframe_ck", 0, ck_o[0], 1'b1);
        chk1("midframe_d", 0, d_o[0], 1'b1);
        chk1("midframe_lr", 0, lr_o[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        repeat (3) tick();

        // After release, offer the pair exactly on the first frame start.
        set_pair(16'h0, 16'h0, 24'h0, 24'h0, 1'b0);
        release_rst();
        repeat (31) tick();
        set_pair(16'hA5F0, 16'h0F5A, 24'h800001, 24'h123456, 1'b1);
        tick();
        v_ab = 1'b0;
        v_c  = 1'b0;
        chk1("coincide_ready", 0, rdy[0], 1'b1);
        chk1("coincide_underrun", 0, un_o[0], 1'b0);
        repeat (1068) tick();
        chk("restart_d", 0, 64'(cap_d[0][63:32]), 64'h00000000A5F00F5A);
        chk("restart_lr", 0, 64'(cap_l[0][63:32]), 64'h000000000001FFFE);
        chk("restart_underruns", 0, 64'(un_cnt[0]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
